// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the RV32 hazard controller: forwarding selects and
// multi-cycle EX FSM states.
package hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

endpackage

// File: rtl/hazard_ctrl_mc_busy_fsm.sv
// Multi-cycle EX busy tracker: holds the op in EX for MC_LAT cycles by raising
// mc_busy for the first MC_LAT-1 of them; frozen while data memory stalls.
module mc_busy_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mc_start_e,
  input  logic mem_busy,
  output logic mc_busy
);

  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
  localparam logic MC_EN = (MC_LAT >= 2);
  localparam logic [CW-1:0] CNT_LOAD = (MC_LAT >= 2) ? CW'(MC_LAT - 2) : '0;

  mc_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new start is only accepted from IDLE; cnt==0 in BUSY is the release cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!mem_busy) begin
      case (state_q)
        IDLE: begin
          if (mc_start_e && MC_EN) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mc_busy = 1'b0;
    case (state_q)
      IDLE:    mc_busy = mc_start_e & MC_EN;
      BUSY:    mc_busy = (cnt_q != '0);
      default: mc_busy = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and multi-cycle
// stalls, branch flushes, memory freeze and saturating stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_e,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              load_e,
  input  logic              mc_start_e,
  input  logic              pcsrc_e,
  input  logic              mem_busy,
  input  logic              cnt_clr,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic [1:0]        forwarda_e,
  output logic [1:0]        forwardb_e,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  function automatic fwd_sel_t fwd_pick(input logic [REG_AW-1:0] rs);
    if (regwrite_m && (rd_m != '0) && (rd_m == rs))      return FWD_MEM;
    else if (regwrite_w && (rd_w != '0) && (rd_w == rs)) return FWD_WB;
    else                                                 return FWD_RF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  fwd_sel_t         fwd_a, fwd_b;
  logic             lu;
  logic             mc_busy_w;
  logic             flush_br;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  mc_busy_fsm #(.MC_LAT(MC_LAT)) u_mc_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .mc_start_e (mc_start_e),
    .mem_busy   (mem_busy),
    .mc_busy    (mc_busy_w)
  );

  always_comb begin
    fwd_a = fwd_pick(rs1_e);
    fwd_b = fwd_pick(rs2_e);
  end

  assign forwarda_e = fwd_a;
  assign forwardb_e = fwd_b;
  assign mc_busy    = mc_busy_w;

  assign lu = load_e & regwrite_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));

  // A branch blocked by mem_busy is not lost: EX is held, so pcsrc_e re-presents.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    flush_br = 1'b0;
    if (mem_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else if (mc_busy_w) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
    end else if (pcsrc_e) begin
      flush_d  = 1'b1;
      flush_e  = 1'b1;
      flush_br = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_f)  stall_cnt_d = sat_inc(stall_cnt_q);
      if (flush_br) flush_cnt_d = sat_inc(flush_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a reference model pushes expected outputs to
// a scoreboard each cycle and they are popped and compared against the DUT.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          regwrite_e, regwrite_m, regwrite_w, load_e, mc_start_e, pcsrc_e, mem_busy, cnt_clr;

  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, mc_busy;
  logic [1:0]    forwarda_e, forwardb_e;
  logic [CW-1:0] stall_cnt, flush_cnt;

  logic          stall_f1, stall_d1, stall_e1, stall_m1, flush_d1, flush_e1, flush_m1, mc_busy1;
  logic [1:0]    forwarda_e1, forwardb_e1;
  logic [CW-1:0] stall_cnt1, flush_cnt1;

  hazard_ctrl #(.REG_AW(AW), .MC_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w), .load_e(load_e), .mc_start_e(mc_start_e), .pcsrc_e(pcsrc_e),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e),
    .flush_m(flush_m), .forwarda_e(forwarda_e), .forwardb_e(forwardb_e), .mc_busy(mc_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.REG_AW(AW), .MC_LAT(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_e(regwrite_e), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w), .load_e(load_e), .mc_start_e(mc_start_e), .pcsrc_e(pcsrc_e),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr), .stall_f(stall_f1), .stall_d(stall_d1),
    .stall_e(stall_e1), .stall_m(stall_m1), .flush_d(flush_d1), .flush_e(flush_e1),
    .flush_m(flush_m1), .forwarda_e(forwarda_e1), .forwardb_e(forwardb_e1), .mc_busy(mc_busy1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  logic [12:0] ctrl_obs;
  assign ctrl_obs = {forwarda_e, forwardb_e, stall_f, stall_d, stall_e, stall_m,
                     flush_d, flush_e, flush_m, mc_busy};

  typedef struct {
    string         tag;
    logic [12:0]   ctrl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic          chk1;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: EX cycles elapsed of the current multi-cycle op (0 = none).
  int            m_phase = 0;
  logic [CW-1:0] m_sc = '0;
  logic [CW-1:0] m_fc = '0;
  logic          chk1 = 1'b0;

  function automatic logic [1:0] fwd_exp(input logic [AW-1:0] rs);
    if (regwrite_m && rd_m != 0 && rd_m == rs)      return 2'b10;
    else if (regwrite_w && rd_w != 0 && rd_w == rs) return 2'b01;
    else                                            return 2'b00;
  endfunction

  task automatic step(input string tag);
    exp_t e, got;
    logic lu, busy, sf, sd, se, sm, fd, fe, fm, fbr;
    if (!rst_n) begin
      m_phase = 0;
      m_sc    = '0;
      m_fc    = '0;
    end
    lu = load_e && regwrite_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    assert (!(pcsrc_e && (mc_start_e || lu))) else $error("illegal stimulus combination at %s", tag);
    busy = (m_phase == 0) ? (mc_start_e && LAT >= 2) : (m_phase < LAT - 1);
    {sf, sd, se, sm, fd, fe, fm, fbr} = '0;
    if (mem_busy)     {sf, sd, se, sm} = 4'b1111;
    else if (busy)    {sf, sd, se, fm} = 4'b1111;
    else if (pcsrc_e) {fd, fe, fbr}    = 3'b111;
    else if (lu)      {sf, sd, fe}     = 3'b111;
    e.tag  = tag;
    e.ctrl = {fwd_exp(rs1_e), fwd_exp(rs2_e), sf, sd, se, sm, fd, fe, fm, busy};
    e.sc   = m_sc;
    e.fc   = m_fc;
    e.chk1 = chk1;
    sbq.push_back(e);
    #1;
    got = sbq.pop_front();
    checks++;
    assert (ctrl_obs === got.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl: observed=%b expected=%b", got.tag, ctrl_obs, got.ctrl);
    end
    checks++;
    assert (stall_cnt === got.sc) else begin
      errors++;
      $error("FAIL %s stall_cnt: observed=%0d expected=%0d", got.tag, stall_cnt, got.sc);
    end
    checks++;
    assert (flush_cnt === got.fc) else begin
      errors++;
      $error("FAIL %s flush_cnt: observed=%0d expected=%0d", got.tag, flush_cnt, got.fc);
    end
    if (got.chk1) begin
      checks++;
      assert ({stall_f1, stall_e1, flush_m1, mc_busy1} === 4'b0000) else begin
        errors++;
        $error("FAIL %s lat1_stall: observed=%b expected=0000", got.tag,
               {stall_f1, stall_e1, flush_m1, mc_busy1});
      end
    end
    if (rst_n) begin
      if (!mem_busy) begin
        if (m_phase == 0) begin
          if (mc_start_e && LAT >= 2) m_phase = 1;
        end else begin
          m_phase = (m_phase == LAT - 1) ? 0 : m_phase + 1;
        end
      end
      if (cnt_clr) begin
        m_sc = '0;
        m_fc = '0;
      end else begin
        if (sf  && m_sc != '1) m_sc = m_sc + 1'b1;
        if (fbr && m_fc != '1) m_fc = m_fc + 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {regwrite_e, regwrite_m, regwrite_w, load_e, mc_start_e, pcsrc_e, mem_busy, cnt_clr} = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    step("reset");
    rst_n = 1'b1;
    step("idle");

    rd_m = 5; rd_w = 5; regwrite_m = 1; regwrite_w = 1; rs1_e = 5; rs2_e = 0;
    step("fwd_mem");
    regwrite_m = 0;
    step("fwd_wb");
    regwrite_m = 1; rd_m = 0; rd_w = 0; rs1_e = 0;
    step("fwd_x0");
    rd_m = 3; rd_w = 9; rs1_e = 9; rs2_e = 3;
    step("fwd_mix");
    clear_inputs();

    load_e = 1; regwrite_e = 1; rd_e = 7; rs2_d = 7;
    step("lu");
    rd_e = 0; rs2_d = 0;
    step("lu_x0");
    clear_inputs();
    step("lu_after");

    chk1 = 1'b1;
    mc_start_e = 1;
    for (int i = 0; i < 4; i++) step($sformatf("mc_c%0d", i));
    mc_start_e = 0;
    step("mc_idle");
    chk1 = 1'b0;

    mc_start_e = 1;
    step("mb_c0");
    mem_busy = 1;
    step("mb_c1");
    step("mb_c2");
    mem_busy = 0;
    for (int i = 3; i < 6; i++) step($sformatf("mb_c%0d", i));
    mc_start_e = 0;
    step("mb_idle");

    pcsrc_e = 1; mem_busy = 1;
    step("br_frozen");
    mem_busy = 0;
    step("br_taken");
    pcsrc_e = 0;
    step("br_after");

    mc_start_e = 1;
    step("rb_c0");
    step("rb_c1");
    rst_n = 0; mc_start_e = 0;
    step("rst_busy");
    rst_n = 1;
    step("rst_release");

    load_e = 1; regwrite_e = 1; rd_e = 4; rs1_d = 4;
    for (int i = 0; i < 70; i++) step($sformatf("sat_%0d", i));
    cnt_clr = 1;
    step("clr_inc");
    cnt_clr = 0;
    step("clr_after");
    clear_inputs();
    step("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
